jk_seq_ctrl: RTL

JK_SEQ_CTRL -- requirements
Module: jk_seq_ctrl

---
 rtl/jk_seq_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/jk_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jk_seq_ctrl
// Purpose  : Sequencing controller for an external bank of WIDTH JK
//            flip-flops. Accepts CLEAR / LOAD / UP / DOWN commands and drives
//            per-bit J/K so the bank walks to the requested value, using the
//            bank outputs (q) as feedback.
// Ports    : clk        - clock, rising edge active
//            reset      - synchronous, active-low reset
//            cmd_valid  - command presented
//            cmd_ready  - command accepted this cycle (IDLE and out of reset)
//            cmd_op     - 00 CLEAR, 01 LOAD, 10 UP, 11 DOWN
//            cmd_data   - LOAD value, or step count N for UP/DOWN
//            abort      - ends a running command early
//            q          - bank outputs fed back
//            j, k       - per-bit J/K drives to the bank
//            busy       - state is not IDLE
//            done       - one-cycle completion pulse
//            aborted    - qualifies done: command ended by abort
// Revision : 1.0 - initial release
// ============================================================================
module jk_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [1:0] c_op_clear = 2'b00;
    localparam logic [1:0] c_op_load  = 2'b01;
    localparam logic [1:0] c_op_up    = 2'b10;
    localparam logic [1:0] c_op_down  = 2'b11;

    localparam logic [WIDTH-1:0] c_cnt_zero = '0;
    localparam logic [WIDTH-1:0] c_cnt_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_cnt;
    logic             r_aborted;

    logic [WIDTH-1:0] w_target;
    logic             w_drive;

    // ------------------------------------------------------------------------
    // Control FSM. In IDLE with reset high, cmd_ready is 1, so cmd_valid
    // alone marks an accepting edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= c_st_idle;
            r_op      <= c_op_clear;
            r_data    <= '0;
            r_cnt     <= '0;
            r_aborted <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid) begin
                        r_op      <= cmd_op;
                        r_data    <= cmd_data;
                        r_aborted <= 1'b0;
                        if (cmd_op == c_op_clear || cmd_op == c_op_load) begin
                            r_cnt   <= c_cnt_one;
                            r_state <= c_st_run;
                        end else begin
                            r_cnt   <= cmd_data;
                            // A zero-step UP/DOWN completes without touching the bank.
                            r_state <= (cmd_data == c_cnt_zero) ? c_st_done : c_st_run;
                        end
                    end
                end
                c_st_run: begin
                    if (abort) begin
                        // Abort beats a coinciding final step; J/K are
                        // already forced to zero this cycle.
                        r_aborted <= 1'b1;
                        r_state   <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                        if (r_cnt == c_cnt_one) begin
                            r_state <= c_st_done;
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Per-cycle target for the bank while running.
    // ------------------------------------------------------------------------
    always_comb begin
        w_target = '0;
        case (r_op)
            c_op_clear: w_target = '0;
            c_op_load:  w_target = r_data;
            c_op_up:    w_target = q + c_cnt_one;
            c_op_down:  w_target = q - c_cnt_one;
            default:    w_target = '0;
        endcase
    end

    // Drives are gated by reset as well so a reset edge never moves the bank.
    assign w_drive = (r_state == c_st_run) && !abort && reset;

    // Set where target is 1 and bank is 0, reset where target is 0 and bank
    // is 1, hold otherwise.
    assign j = w_drive ? (w_target & ~q) : '0;
    assign k = w_drive ? (~w_target & q) : '0;

    assign cmd_ready = (r_state == c_st_idle) && reset;
    assign busy      = (r_state != c_st_idle);
    assign done      = (r_state == c_st_done);
    assign aborted   = r_aborted;

endmodule
`default_nettype wire
